ob: RTL

OB -- requirements
Module: ob

---
 rtl/ob_pkg.sv | 26 ++
 rtl/ob_rrarb.sv | 26 ++
 rtl/ob.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ob_pkg.sv
// Shared flit-format constants and types for the output buffer (ob) and its arbiter.
package ob_pkg;
  localparam int PKTW    = 15;
  localparam int PORT    = 4;
  localparam int FLOWBH  = 15;
  localparam int FLOWBL  = 14;
  localparam int OBDEPTH = 4;
  localparam int PTRW    = $clog2(OBDEPTH);
  localparam int CNTW    = $clog2(OBDEPTH) + 1;

  typedef enum logic [1:0] {
    FT_IDLE = 2'b00,
    FT_HEAD = 2'b01,
    FT_BODY = 2'b10,
    FT_TAIL = 2'b11
  } flit_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  function automatic flit_t flit_type(input logic [PKTW:0] f);
    return flit_t'(f[FLOWBH:FLOWBL]);
  endfunction
endpackage

// File: rtl/ob_rrarb.sv
// Combinational round-robin picker: first requester at or after (last+1) mod 4.
module rrarb (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] g
);
  logic [1:0] idx_s;
  logic [1:0] g_s;
  logic       found_s;

  // scan ports in priority order starting just after the previous winner
  always_comb begin
    idx_s   = 2'd0;
    g_s     = 2'd0;
    found_s = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx_s   = last + k[1:0];
      g_s     = (!found_s && req[idx_s]) ? idx_s : g_s;
      found_s = found_s | req[idx_s];
    end
  end

  assign valid = found_s;
  assign g     = g_s;
endmodule

// File: rtl/ob.sv
// Output-port buffer: round-robin packet arbitration, 4-deep flit FIFO, registered output.
module ob
  import ob_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  output logic [3:0]    ack,
  input  logic [PKTW:0] pkti0,
  input  logic [PKTW:0] pkti1,
  input  logic [PKTW:0] pkti2,
  input  logic [PKTW:0] pkti3,
  input  logic          dfull,
  output logic [PKTW:0] pkto
);
  state_t          state_r, state_s;
  logic [1:0]      g_r, g_s;
  logic [1:0]      last_r, last_s;
  logic            rr_valid_s;
  logic [1:0]      rr_g_s;
  logic [PKTW:0]   flit_s;
  logic [3:0]      ack_s;
  logic            wr_s, rd_s, full_s;
  logic [PKTW:0]   mem_r [OBDEPTH];
  logic [PTRW-1:0] wptr_r, rptr_r;
  logic [CNTW-1:0] cnt_r;
  logic [PKTW:0]   pkto_r;

  rrarb u_rrarb (
    .req   (req),
    .last  (last_r),
    .valid (rr_valid_s),
    .g     (rr_g_s)
  );

  // flit mux selecting the granted input buffer's head
  always_comb begin
    flit_s = pkti0;
    case (g_r)
      2'd0:    flit_s = pkti0;
      2'd1:    flit_s = pkti1;
      2'd2:    flit_s = pkti2;
      2'd3:    flit_s = pkti3;
      default: flit_s = pkti0;
    endcase
  end

  assign full_s = (cnt_r == CNTW'(OBDEPTH));
  assign rd_s   = (cnt_r != {CNTW{1'b0}}) && !dfull;

  // next-state, grant capture, ack and FIFO write enable
  always_comb begin
    state_s = state_r;
    g_s     = g_r;
    last_s  = last_r;
    ack_s   = 4'b0000;
    wr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rr_valid_s) begin
          state_s = ST_XFER;
          g_s     = rr_g_s;
          last_s  = rr_g_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (!full_s) begin
          ack_s = 4'b0001 << g_r;
          // idle flits are popped from the input but never stored
          if (flit_type(flit_s) != FT_IDLE) begin
            wr_s = 1'b1;
            if (flit_type(flit_s) == FT_TAIL) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_XFER;
            end
          end else begin
            wr_s = 1'b0;
          end
        end else begin
          ack_s = 4'b0000;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // control state, FIFO pointers/occupancy and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      g_r     <= 2'd0;
      last_r  <= 2'd3;
      wptr_r  <= {PTRW{1'b0}};
      rptr_r  <= {PTRW{1'b0}};
      cnt_r   <= {CNTW{1'b0}};
      pkto_r  <= {(PKTW+1){1'b0}};
    end else begin
      state_r <= state_s;
      g_r     <= g_s;
      last_r  <= last_s;
      if (wr_s) begin
        wptr_r <= wptr_r + PTRW'(1);
      end
      if (rd_s) begin
        rptr_r <= rptr_r + PTRW'(1);
      end
      case ({wr_s, rd_s})
        2'b10:   cnt_r <= cnt_r + CNTW'(1);
        2'b01:   cnt_r <= cnt_r - CNTW'(1);
        default: cnt_r <= cnt_r;
      endcase
      pkto_r <= rd_s ? mem_r[rptr_r] : {(PKTW+1){1'b0}};
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wptr_r] <= flit_s;
    end
  end

  assign ack  = ack_s;
  assign pkto = pkto_r;
endmodule
